// File: rtl/mac_10g_tx_framer_pkg.sv
// Shared types and helpers for the 10G MAC transmit framer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
//
// Holds the stream widths shared with the rest of the MAC, the read-side
// FSM state encoding, the word format stored in the input FIFO and the
// tail-byte masking helper.
package mac_10g_tx_framer_pkg;

    localparam int MAC_DWIDTH    = 64;
    localparam int MAC_MOD_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAD  = 2'd2,
        IPG  = 2'd3
    } tx_state_e;

    // One buffered packet word with its framing side-band.
    typedef struct packed {
        logic [MAC_DWIDTH-1:0]    data;
        logic                     sop;
        logic                     eop;
        logic [MAC_MOD_WIDTH-1:0] empty;
        logic                     error;
    } tx_word_t;

    // Byte 0 sits in the MSBs, so invalid tail bytes are the low lanes:
    // lane i (bits [8i+7:8i]) is cleared when i < empty.
    function automatic logic [MAC_DWIDTH-1:0] mask_tail(
        input logic [MAC_DWIDTH-1:0]    d,
        input logic [MAC_MOD_WIDTH-1:0] empty
    );
        logic [MAC_DWIDTH-1:0] m;
        m = d;
        for (int i = 0; i < MAC_DWIDTH / 8; i++) begin
            if (i < int'(empty)) begin
                m[i*8 +: 8] = 8'h00;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/mac_10g_tx_fifo.sv
// Synchronous word FIFO between the upstream write side and the framer read FSM.
// Latency: a word written at edge N is visible on rd_dat after edge N (first-word fall-through from registers).
// Backpressure: full asserted at DEPTH entries; pushes while full and pops while empty are ignored.
//
// Ports: core_clk/arst_n clock and async reset (flushes), wr_vld/wr_dat push,
// rd_rdy pop of the head word, rd_dat head word, full/empty status.
module mac_10g_tx_fifo #(
    parameter int W     = 70,
    parameter int DEPTH = 8
) (
    input  logic         core_clk,
    input  logic         arst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_push = wr_vld && !full;
    assign do_pop  = rd_rdy && !empty;
    assign rd_dat  = mem[rd_ptr];

    always_ff @(posedge core_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mac_10g_tx_framer.sv
// Transmit framer: buffers upstream packet words, repairs framing faults, pads short frames, inserts IPG.
// Latency: word accepted in cycle N appears on the stream outputs in cycle N+2 (FIFO empty, IDLE, clk_en=1).
// Backpressure: o_tx_ready = !fifo_full (held low for one cycle after reset); read side advances only on i_clk_en.
//
// Ports: i_clk/i_rst_n clock and async active-low reset; i_clk_en output-side rate strobe;
// i_tx_* / o_tx_ready upstream valid/ready word interface; o_dv/o_data_en/o_data/o_sop/o_eop/
// o_empty/o_error registered MAC stream; o_pkt_cnt completed frames; o_framing_err fault pulse.
module mac_10g_tx_framer
    import mac_10g_tx_framer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int IPG_CYCLES = 2,
    parameter int MIN_WORDS  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clk_en,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    input  logic [MAC_DWIDTH-1:0]    i_tx_data,
    input  logic                     i_tx_sop,
    input  logic                     i_tx_eop,
    input  logic [MAC_MOD_WIDTH-1:0] i_tx_empty,
    input  logic                     i_tx_error,
    output logic                     o_dv,
    output logic                     o_data_en,
    output logic [MAC_DWIDTH-1:0]    o_data,
    output logic                     o_sop,
    output logic                     o_eop,
    output logic [MAC_MOD_WIDTH-1:0] o_empty,
    output logic                     o_error,
    output logic [31:0]              o_pkt_cnt,
    output logic                     o_framing_err
);

    localparam int              CW        = $clog2(MIN_WORDS + 1);
    localparam logic [CW-1:0]   MIN_W     = CW'(MIN_WORDS);
    localparam logic [3:0]      IPG_LAST  = 4'(IPG_CYCLES - 1);
    localparam tx_state_e       AFTER_EOP = (IPG_CYCLES == 0) ? IDLE : IPG;
    localparam int              WW        = $bits(tx_word_t);

    // ---------------- write side ----------------
    logic     rdy_en;
    logic     in_frame;
    logic     fifo_full;
    logic     fifo_empty;
    logic     accept;
    logic     drop;
    logic     fix_sop;
    logic     push;
    logic     pop;
    tx_word_t wr_word;
    tx_word_t head;
    logic [WW-1:0] head_vec;

    assign o_tx_ready = rdy_en && !fifo_full;
    assign accept     = i_tx_valid && o_tx_ready;
    // A continuation word with no open frame has nowhere to go.
    assign drop       = accept && !in_frame && !i_tx_sop;
    // A second sop inside a frame is folded into the current frame.
    assign fix_sop    = accept && in_frame && i_tx_sop;
    assign push       = accept && !drop;
    assign head       = tx_word_t'(head_vec);

    always_comb begin
        wr_word.data  = i_tx_data;
        wr_word.sop   = i_tx_sop && !in_frame;
        wr_word.eop   = i_tx_eop;
        wr_word.empty = i_tx_empty;
        wr_word.error = i_tx_error;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rdy_en        <= 1'b0;
            in_frame      <= 1'b0;
            o_framing_err <= 1'b0;
        end else begin
            rdy_en        <= 1'b1;
            o_framing_err <= drop || fix_sop;
            if (push) begin
                in_frame <= !i_tx_eop;
            end
        end
    end

    mac_10g_tx_fifo #(
        .W     (WW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk (i_clk),
        .arst_n   (i_rst_n),
        .wr_vld   (push),
        .wr_dat   (wr_word),
        .rd_rdy   (pop),
        .rd_dat   (head_vec),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ---------------- read side ----------------
    tx_state_e                state;
    tx_state_e                state_nxt;
    logic [CW-1:0]            word_cnt;
    logic [CW-1:0]            word_cnt_nxt;
    logic [CW-1:0]            cnt_inc;
    logic [CW-1:0]            emit_cnt;
    logic                     err_lat;
    logic                     err_lat_nxt;
    logic [3:0]               ipg_cnt;
    logic [3:0]               ipg_cnt_nxt;
    logic                     pop_c;
    logic                     emit;
    logic                     dv_nxt;
    logic                     data_en_nxt;
    logic [MAC_DWIDTH-1:0]    data_nxt;
    logic                     sop_nxt;
    logic                     eop_nxt;
    logic [MAC_MOD_WIDTH-1:0] empty_nxt;
    logic                     error_nxt;

    assign cnt_inc = (word_cnt >= MIN_W) ? MIN_W : word_cnt + CW'(1);
    assign pop     = i_clk_en && pop_c;

    always_comb begin
        state_nxt    = state;
        word_cnt_nxt = word_cnt;
        err_lat_nxt  = err_lat;
        ipg_cnt_nxt  = ipg_cnt;
        dv_nxt       = o_dv;
        data_en_nxt  = 1'b0;
        data_nxt     = o_data;
        sop_nxt      = 1'b0;
        eop_nxt      = 1'b0;
        empty_nxt    = '0;
        error_nxt    = 1'b0;
        pop_c        = 1'b0;
        emit         = 1'b0;
        emit_cnt     = cnt_inc;

        unique case (state)
            IDLE: begin
                dv_nxt = 1'b0;
                // A non-sop head cannot normally occur; it is discarded.
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    if (head.sop) begin
                        emit     = 1'b1;
                        emit_cnt = CW'(1);
                    end
                end
            end
            SEND: begin
                // Empty FIFO mid-frame: hold the envelope open without data.
                dv_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    emit  = 1'b1;
                end
            end
            PAD: begin
                dv_nxt       = 1'b1;
                data_en_nxt  = 1'b1;
                data_nxt     = '0;
                word_cnt_nxt = cnt_inc;
                if (cnt_inc >= MIN_W) begin
                    eop_nxt     = 1'b1;
                    error_nxt   = err_lat;
                    state_nxt   = AFTER_EOP;
                    ipg_cnt_nxt = '0;
                end
            end
            IPG: begin
                dv_nxt = 1'b0;
                if (ipg_cnt == IPG_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    ipg_cnt_nxt = ipg_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (emit) begin
            dv_nxt       = 1'b1;
            data_en_nxt  = 1'b1;
            sop_nxt      = head.sop;
            word_cnt_nxt = emit_cnt;
            state_nxt    = SEND;
            data_nxt     = head.eop ? mask_tail(head.data, head.empty) : head.data;
            if (head.eop) begin
                if (emit_cnt >= MIN_W) begin
                    eop_nxt     = 1'b1;
                    empty_nxt   = head.empty;
                    error_nxt   = head.error;
                    state_nxt   = AFTER_EOP;
                    ipg_cnt_nxt = '0;
                end else begin
                    // Short frame: the real eop moves to the last pad word.
                    err_lat_nxt = head.error;
                    state_nxt   = PAD;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            word_cnt  <= '0;
            err_lat   <= 1'b0;
            ipg_cnt   <= '0;
            o_dv      <= 1'b0;
            o_data_en <= 1'b0;
            o_data    <= '0;
            o_sop     <= 1'b0;
            o_eop     <= 1'b0;
            o_empty   <= '0;
            o_error   <= 1'b0;
            o_pkt_cnt <= '0;
        end else if (i_clk_en) begin
            state     <= state_nxt;
            word_cnt  <= word_cnt_nxt;
            err_lat   <= err_lat_nxt;
            ipg_cnt   <= ipg_cnt_nxt;
            o_dv      <= dv_nxt;
            o_data_en <= data_en_nxt;
            o_data    <= data_nxt;
            o_sop     <= sop_nxt;
            o_eop     <= eop_nxt;
            o_empty   <= empty_nxt;
            o_error   <= error_nxt;
            if (eop_nxt) begin
                o_pkt_cnt <= o_pkt_cnt + 32'd1;
            end
        end
    end

endmodule
